// File: rtl/coef_ram_loader.sv
// Writer side of the lowpass coefficient RAM: parses the framed host byte stream and writes coefficients.
// Optional trailing checksum byte enabled by defining COEF_LOADER_CHECKSUM_EN.
module coef_ram_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 480000,
  parameter int         TO_W           = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [6:0] RAM_coefs_wr_addr,
  output logic [7:0] RAM_coefs_datain,
  output logic       RAM_coefs_we,
  output logic       busy,
  output logic       load_done,
  output logic       load_err,
  output logic       coefs_valid
);

  typedef enum logic [2:0] {
    IDLE, GET_START, GET_COUNT, GET_DATA, WRITE, ERROR
`ifdef COEF_LOADER_CHECKSUM_EN
    , GET_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              done_q, done_d;
  logic              cv_q, cv_d;
  logic              accept, timeout_hit;

  assign accept      = rx_valid & rx_ready;
  assign timeout_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef COEF_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      case (state_q)
        GET_START:          sum_d = rx_data;
        GET_COUNT, GET_DATA: sum_d = sum_q + rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    cv_d    = cv_q;
    done_d  = 1'b0;
    to_d    = (state_q == IDLE || accept) ? '0 : to_q + TO_W'(1);
    case (state_q)
      IDLE:
        if (accept && rx_data == SYNC_BYTE) state_d = GET_START;
      GET_START:
        if (accept) begin
          if (rx_data[7]) state_d = ERROR;
          else begin
            addr_d  = rx_data[6:0];
            state_d = GET_COUNT;
          end
        end
      GET_COUNT:
        if (accept) begin
          if (rx_data > 8'd128) state_d = ERROR;
          else begin
            cnt_d   = (rx_data == 8'd0) ? 8'd128 : rx_data;
            cv_d    = 1'b0;
            state_d = GET_DATA;
          end
        end
      GET_DATA:
        if (accept) begin
          data_d  = rx_data;
          state_d = WRITE;
        end
      WRITE: begin
        addr_d = addr_q + 7'd1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
`ifdef COEF_LOADER_CHECKSUM_EN
          state_d = GET_CSUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
          cv_d    = 1'b1;
`endif
        end else begin
          state_d = GET_DATA;
        end
      end
`ifdef COEF_LOADER_CHECKSUM_EN
      GET_CSUM:
        if (accept) begin
          if (rx_data == sum_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cv_d    = 1'b1;
          end else begin
            state_d = ERROR;
          end
        end
`endif
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Inter-byte watchdog: only meaningful while a frame is open and waiting on the host.
    if (state_q != IDLE && state_q != ERROR && !accept && timeout_hit) state_d = ERROR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      done_q  <= done_d;
      cv_q    <= cv_d;
    end
  end

  assign rx_ready          = (state_q != WRITE) && (state_q != ERROR);
  // Reset gates the strobe directly so a write pending in the reset cycle never lands.
  assign RAM_coefs_we      = (state_q == WRITE) && !reset;
  assign RAM_coefs_wr_addr = addr_q;
  assign RAM_coefs_datain  = data_q;
  assign busy              = (state_q != IDLE);
  assign load_err          = (state_q == ERROR);
  assign load_done         = done_q;
  assign coefs_valid       = cv_q;

endmodule

// File: tb/tb_coef_ram_loader.sv
// Directed bench for coef_ram_loader: RAM writes checked against a scoreboard of expected (addr, data).
module tb_coef_ram_loader;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [6:0] RAM_coefs_wr_addr;
  logic [7:0] RAM_coefs_datain;
  logic       RAM_coefs_we, busy, load_done, load_err, coefs_valid;

  coef_ram_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .RAM_coefs_wr_addr(RAM_coefs_wr_addr), .RAM_coefs_datain(RAM_coefs_datain),
    .RAM_coefs_we(RAM_coefs_we), .busy(busy), .load_done(load_done), .load_err(load_err),
    .coefs_valid(coefs_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [6:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] dq[$];
  int         pass_cnt = 0, total_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [6:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples the current cycle's outputs; RAM writes must match the scoreboard head.
  task automatic monitor();
    wr_t e;
    if (RAM_coefs_we) begin
      we_cnt++;
      last_addr = RAM_coefs_wr_addr;
      chk("sb_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_write", {RAM_coefs_wr_addr, RAM_coefs_datain}, {e.a, e.d});
      end
    end
    if (load_done) done_cnt++;
    if (load_err)  err_cnt++;
  endtask

  task automatic cyc();
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Presents b until accepted; leaves rx_valid high so back-to-back bytes stream.
  task automatic send(input logic [7:0] b, input bit push, input logic [6:0] a);
    int   n = 0;
    logic acc;
    if (push) exp_q.push_back('{a: a, d: b});
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      acc = rx_ready;
      cyc();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic frame(input logic [7:0] start, input logic [7:0] count, input bit gap,
                       input bit bad_csum);
    logic [6:0] a   = start[6:0];
    logic [7:0] sum = start + count;
    int         w0  = we_cnt;
    send(SYNC, 0, 0);  if (gap) idle(1);
    send(start, 0, 0); if (gap) idle(1);
    send(count, 0, 0);
    foreach (dq[i]) begin
      if (gap) idle(1);
      send(dq[i], 1, a);
      chk("rdy_low_in_write", rx_ready, 0);
      a++;
      sum += dq[i];
    end
`ifdef COEF_LOADER_CHECKSUM_EN
    send(bad_csum ? sum + 8'd1 : sum, 0, 0);
    rx_valid = 1'b0;
    chk("csum_done", load_done, !bad_csum);
    chk("csum_err", load_err, bad_csum);
    chk("csum_cv", coefs_valid, !bad_csum);
`else
    rx_valid = 1'b0;
    chk("last_we", RAM_coefs_we, 1);
    chk("done_not_early", load_done, 0);
    cyc();
    chk("load_done", load_done, 1);
    chk("coefs_valid_set", coefs_valid, !bad_csum);
`endif
    cyc();
    chk("busy_cleared", busy, 0);
    chk("done_one_cycle", load_done, 0);
    chk("we_count", we_cnt - w0, dq.size());
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n, w0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_ready", rx_ready, 1);
    chk("rst_outs", {RAM_coefs_we, busy, load_done, load_err, coefs_valid}, 0);
    chk("rst_addr_data", {RAM_coefs_wr_addr, RAM_coefs_datain}, 0);

    // Non-sync bytes in IDLE are dropped.
    send(8'h3C, 0, 0); rx_valid = 1'b0;
    chk("idle_discard", busy, 0);
    cyc();

    // Basic load with gaps between bytes.
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(8'h00, 8'h04, 1, 0);

    // Back-pressure with continuous valid; mid-frame sync value is plain data.
    dq = '{8'hAA, SYNC, 8'hBB};
    frame(8'h10, 8'h03, 0, 0);

    // COUNT = 0 loads 128 entries with address wrap.
    dq.delete();
    for (int i = 0; i < 128; i++) dq.push_back(8'(i));
    frame(8'h7E, 8'h00, 0, 0);
    chk("wrap_last_addr", last_addr, 7'h7D);

    // Bad START and bad COUNT.
    w0 = we_cnt;
    send(SYNC, 0, 0); send(8'h80, 0, 0); rx_valid = 1'b0;
    chk("start_err", load_err, 1);
    chk("err_ready_low", rx_ready, 0);
    cyc();
    send(SYNC, 0, 0); send(8'h00, 0, 0); send(8'h81, 0, 0); rx_valid = 1'b0;
    chk("count_err", load_err, 1);
    chk("count_err_cv_kept", coefs_valid, 1);
    cyc();
    chk("err_no_we", we_cnt - w0, 0);
    chk("err_pulse_one_cycle", load_err, 0);

    // Inter-byte timeout after one of two data bytes.
    w0 = we_cnt;
    send(SYNC, 0, 0); send(8'h00, 0, 0); send(8'h02, 0, 0); send(8'h55, 1, 7'd0);
    rx_valid = 1'b0;
    n = 0;
    while (!load_err && n < TO + 20) begin cyc(); n++; end
    chk("timeout_err", load_err, 1);
    chk("timeout_window", (n >= TO - 2) && (n <= TO + 2), 1);
    chk("timeout_cv", coefs_valid, 0);
    chk("timeout_one_write", we_cnt - w0, 1);
    cyc();

    // Recovery frame after the timeout.
    dq = '{8'h77};
    frame(8'h05, 8'h01, 0, 0);

`ifdef COEF_LOADER_CHECKSUM_EN
    dq = '{8'h10, 8'h20};
    frame(8'h00, 8'h02, 0, 0);
    frame(8'h00, 8'h02, 0, 1);
`endif

    // Reset while a write is pending.
    send(SYNC, 0, 0); send(8'h00, 0, 0); send(8'h02, 0, 0); send(8'h99, 0, 0);
    rx_valid = 1'b0;
    chk("pre_rst_we", RAM_coefs_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_we_suppressed", RAM_coefs_we, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midrst_ready", rx_ready, 1);
    chk("midrst_outs", {RAM_coefs_we, busy, load_done, load_err, coefs_valid}, 0);
    chk("midrst_addr_data", {RAM_coefs_wr_addr, RAM_coefs_datain}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/coef_ram_loader.md
Name: coef_ram_loader

Overview:
- Writer side of the lowpass coefficient RAM. The lowpass filter reads this RAM through its 7-bit address / 8-bit data port.
- Receives a framed byte stream from the host link (valid/ready handshake), parses it, and writes 8-bit coefficients into the 128-entry RAM.
- Reports frame completion and errors.
- Flags whether the RAM currently holds a complete, accepted coefficient set. Channel control uses this flag to decide whether filtering may be enabled.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 480000, maximum clock cycles between bytes inside a frame before abort (10 ms at 48 MHz).
- TO_W, 19, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready are high on a rising edge
- RAM_coefs_wr_addr  out  7  RAM write address
- RAM_coefs_datain  out  8  RAM write data
- RAM_coefs_we  out  1  RAM write enable, one cycle per coefficient
- busy  out  1  high while a frame is in progress (not IDLE)
- load_done  out  1  one-cycle pulse when a frame completes successfully
- load_err  out  1  one-cycle pulse on a malformed, aborted or timed-out frame
- coefs_valid  out  1  level; RAM holds a complete accepted set

Behaviour:
- Frame format: SYNC_BYTE, START (bit 7 must be 0), COUNT, COUNT data bytes, then [CHECKSUM] if the optional feature is enabled.
- COUNT = 0 means 128 coefficients. COUNT > 128 is an error.
- Reset values:
  - rx_ready = 1.
  - RAM_coefs_we, busy, load_done, load_err, coefs_valid = 0.
  - RAM_coefs_wr_addr and RAM_coefs_datain = 0.
  - FSM in IDLE.
- FSM states: IDLE, GET_START, GET_COUNT, GET_DATA, WRITE, GET_CSUM, ERROR.
- IDLE:
  - On an accepted byte equal to SYNC_BYTE, go to GET_START.
  - Any other byte is silently discarded; stay in IDLE.
- GET_START:
  - If bit 7 = 1, go to ERROR.
  - Otherwise latch address = byte[6:0] and go to GET_COUNT.
- GET_COUNT:
  - If the byte is > 128, go to ERROR.
  - Otherwise latch the remaining count (0 → 128), clear coefs_valid, and go to GET_DATA.
- GET_DATA:
  - Latch the byte into RAM_coefs_datain and go to WRITE.
- WRITE (one cycle):
  - RAM_coefs_we = 1 and rx_ready = 0 for exactly this cycle.
  - The data byte is therefore written on the cycle after its acceptance.
  - Address increments modulo 128: 127 → 0.
  - Remaining count decrements. If it reaches 0, go to GET_CSUM (feature on) or complete (feature off); otherwise return to GET_DATA.
- Complete:
  - load_done pulses for one cycle, coefs_valid = 1, return to IDLE.
  - Total latency from the last data byte accepted to the load_done pulse is 2 cycles.
- ERROR (one cycle):
  - load_err pulses, rx_ready = 0, coefs_valid stays 0 if it was cleared, go to IDLE.
- Timeout:
  - In any state other than IDLE, the counter reloads on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES with no byte accepted, go to ERROR.
  - Data already written stays in RAM; coefs_valid remains 0.
- A SYNC_BYTE value received mid-frame is ordinary data and does not resynchronise.
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values. Any write in flight in that cycle is suppressed (we = 0).
- coefs_valid is cleared only by reset or by an accepted COUNT byte. It is set only on successful completion.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: COEF_LOADER_CHECKSUM_EN.
- Defined:
  - A CHECKSUM byte follows the data.
  - Expected value = 8-bit modulo-256 sum of START, COUNT and all data bytes.
  - On match, complete. On mismatch, go to ERROR; coefs_valid stays 0, the RAM contents are already written and are considered invalid.
  - Latency from the checksum byte accepted to load_done is 1 cycle.
- Undefined:
  - No GET_CSUM state and no checksum byte.
  - The frame completes after the last WRITE.

Test Plan:
- Basic load, feature off. Frame A5, 00, 04, 11, 22, 33, 44 → writes 0x11@0, 0x22@1, 0x33@2, 0x44@3; each we is 1 cycle wide; load_done 2 cycles after 0x44 is accepted; coefs_valid = 1; busy returns to 0.
- Wrap and COUNT = 0. Frame A5, 7E, 00 followed by 128 bytes of value i → first writes go to 0x7E, 0x7F, then 0x00…; exactly 128 we pulses; last address written = 0x7D.
- Errors:
  - START = 0x80 → load_err pulse, no we pulses.
  - COUNT = 0x81 → load_err pulse, no we pulses, coefs_valid previously 1 remains 1.
- Timeout. Frame A5, 00, 02, 55, then idle for TIMEOUT_CYCLES → one write (0x55@0), then load_err; coefs_valid = 0; a following valid frame loads normally.
- Checksum, feature on. Frame A5, 00, 02, 10, 20 with checksum 0x32 → load_done. The same frame with checksum 0x33 → load_err, coefs_valid = 0.
- Reset mid-frame and back-pressure. Assert reset during WRITE → no we pulse, all outputs return to reset values. In a separate run, hold rx_valid high continuously → rx_ready is low exactly one cycle after each data byte and no byte is lost or duplicated.
